// File: rtl/filter_shift_pkg.sv
// Shared definitions for the filter shift arbiter: datapath widths, FSM state
// encoding and the round-robin pick helper.
package filter_shift_pkg;

    localparam int unsigned DATA_W  = 40;
    localparam int unsigned SHIFT_W = 3;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // First set bit of valid, searching upward from ptr and wrapping at num_req.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int unsigned        num_req);
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < num_req) begin
                idx = int'(ptr) + k;
                if (idx >= num_req) idx = idx - num_req;
                if (!found && valid[idx[2:0]]) begin
                    win   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/filter_barrel_shifter.sv
// Logarithmic arithmetic right barrel shifter: data_o = data_i >>> sel_shift,
// sign bit replicated into the vacated positions.
module filter_barrel_shifter
    import filter_shift_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHIFT_W-1:0] sel_shift,
    output logic [DATA_W-1:0]  data_o
);

    logic [DATA_W-1:0] stage;

    // One conditional power-of-two shift stage per select bit.
    always_comb begin
        stage = data_i;
        for (int unsigned b = 0; b < SHIFT_W; b++) begin
            if (sel_shift[b]) begin
                stage = $signed(stage) >>> (32'd1 << b);
            end
        end
    end

    assign data_o = stage;

endmodule

// File: rtl/filter_shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NUM_REQ requesters.
// Flow per result: IDLE (grant + capture) -> SHIFT (register result) -> HOLD
// (wait for out_ready). Optional macro FILTER_SHIFT_PRIO_EN gives requester 0
// strict priority, the others stay round-robin among themselves.
module filter_shift_arbiter
    import filter_shift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*SHIFT_W-1:0] req_shift,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [ID_W-1:0]            out_id,
    input  logic                       out_ready,
    output logic                       busy
);

    state_t             state_q, state_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  cap_data_q;
    logic [SHIFT_W-1:0] cap_shift_q;
    logic [ID_W-1:0]    cap_id_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [ID_W-1:0]    out_id_q;
    logic               out_valid_q;

    logic [MAX_REQ-1:0] valid_ext;
    logic [2:0]         win;
    logic               accept;
    logic [DATA_W-1:0]  sel_data;
    logic [SHIFT_W-1:0] sel_shift;
    logic [DATA_W-1:0]  shift_res;

    // Winner selection, operand mux and the pointer value to load on accept.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
`ifdef FILTER_SHIFT_PRIO_EN
        if (req_valid[0]) begin
            win = '0;
        end else begin
            win = rr_pick(valid_ext & {{(MAX_REQ-1){1'b1}}, 1'b0}, rr_ptr_q, NUM_REQ);
        end
`else
        win = rr_pick(valid_ext, rr_ptr_q, NUM_REQ);
`endif
        sel_data  = '0;
        sel_shift = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == 3'(i)) begin
                sel_data  = req_data[i*DATA_W +: DATA_W];
                sel_shift = req_shift[i*SHIFT_W +: SHIFT_W];
            end
        end
        rr_ptr_d = (win == 3'(NUM_REQ-1)) ? 3'd0 : win + 3'd1;
`ifdef FILTER_SHIFT_PRIO_EN
        // Requester 0 grants leave the rotation of the others untouched.
        if (win == 3'd0) rr_ptr_d = rr_ptr_q;
`endif
    end

    // Next-state and grant decode; req_ready is forced low while in reset.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && (|req_valid)) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (win == 3'(i));
                    end
                end
            end
            SHIFT: state_d = HOLD;
            HOLD: begin
                if (out_valid_q && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture on accept, register the shifted result in SHIFT, clear on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cap_data_q  <= '0;
            cap_shift_q <= '0;
            cap_id_q    <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cap_data_q  <= sel_data;
                cap_shift_q <= sel_shift;
                cap_id_q    <= ID_W'(win);
                rr_ptr_q    <= rr_ptr_d;
            end
            if (state_q == SHIFT) begin
                out_data_q  <= shift_res;
                out_id_q    <= cap_id_q;
                out_valid_q <= 1'b1;
            end else if (state_q == HOLD && out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    filter_barrel_shifter u_shifter (
        .data_i    (cap_data_q),
        .sel_shift (cap_shift_q),
        .data_o    (shift_res)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_filter_shift_arbiter.sv
// Self-checking bench for filter_shift_arbiter: directed scenarios plus a
// randomized phase, all checked cycle by cycle against a transaction-level model.
module tb_filter_shift_arbiter;

    localparam int N  = 4;
    localparam int DW = 40;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N*3-1:0]  req_shift;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic            out_ready;
    logic            busy;

    filter_shift_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one job in flight, result appears two cycles after grant.
    int            m_ptr;
    bit            m_busy, m_ov;
    logic [DW-1:0] m_res, m_cap;
    int            m_id, m_cap_id;

    logic [N-1:0]  obs_rr;
    logic          obs_ov, obs_busy, prev_ov;
    logic [DW-1:0] obs_data;
    int            obs_id;

    int            g_idx[$], g_cyc[$], r_cyc[$], r_id[$];
    logic [DW-1:0] r_data[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int m_pick(input logic [N-1:0] v);
`ifdef FILTER_SHIFT_PRIO_EN
        if (v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (i != 0 && v[i]) return i;
        end
`else
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_busy = 0; m_ov = 0; m_res = '0; m_id = 0;
        m_cap = '0; m_cap_id = 0; prev_ov = 1'b0;
    endtask

    task automatic clear_log();
        g_idx.delete(); g_cyc.delete(); r_cyc.delete(); r_id.delete(); r_data.delete();
    endtask

    // One clock: compare at negedge, log events, advance model, return at posedge+1.
    task automatic tick();
        logic [N-1:0]         exp_rr;
        logic [N-1:0]         one;
        logic signed [DW-1:0] op;
        int                   w, gi;
        @(negedge clk);
        if (!rst_n) model_reset();
        w      = m_pick(req_valid);
        one    = 1;
        exp_rr = (rst_n && !m_busy && req_valid != 0) ? (one << w) : '0;
        check_eq("req_ready", req_ready, exp_rr);
        check_eq("out_valid", out_valid, m_ov);
        check_eq("out_data",  out_data,  m_res);
        check_eq("out_id",    out_id,    m_id);
        check_eq("busy",      busy,      m_busy);
        obs_rr = req_ready; obs_ov = out_valid; obs_busy = busy;
        obs_data = out_data; obs_id = int'(out_id);
        gi = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
        if (gi >= 0) begin g_idx.push_back(gi); g_cyc.push_back(cyc); end
        if (out_valid && !prev_ov) begin
            r_cyc.push_back(cyc); r_data.push_back(out_data); r_id.push_back(int'(out_id));
        end
        prev_ov = out_valid;
        if (rst_n) begin
            if (m_ov) begin
                if (out_ready) begin m_ov = 0; m_busy = 0; end
            end else if (m_busy) begin
                m_ov = 1; m_res = m_cap; m_id = m_cap_id;
            end else if (req_valid != 0) begin
                op       = $signed(req_data[w*DW +: DW]);
                m_cap    = op >>> req_shift[w*3 +: 3];
                m_cap_id = w;
                m_busy   = 1;
`ifdef FILTER_SHIFT_PRIO_EN
                if (w != 0) m_ptr = (w + 1) % N;
`else
                m_ptr = (w + 1) % N;
`endif
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int exp_fair[5];
    int exp_alt[4];
    logic [DW-1:0] hold_data;
    int hold_id;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_shift = '0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single request: requester 1, 0xFFF >>> 3.
        clear_log();
        req_valid = 4'b0010; req_data[1*DW +: DW] = 40'h0000000FFF; req_shift[5:3] = 3'd3;
        out_ready = 1'b1;
        tick();
        req_valid = '0;
        run(5);
        check_eq("single_ngrant", g_idx.size(), 1);
        check_eq("single_nres", r_cyc.size(), 1);
        if (g_idx.size() > 0 && r_cyc.size() > 0) begin
            check_eq("single_gidx", g_idx[0], 1);
            check_eq("single_latency", r_cyc[0] - g_cyc[0], 2);
            check_eq("single_data", r_data[0], 40'h00000001FF);
            check_eq("single_id", r_id[0], 1);
        end

        // Sign extension: requester 0, 0x80_0000_0000 >>> 1.
        clear_log();
        req_valid = 4'b0001; req_data[0 +: DW] = 40'h8000000000; req_shift[2:0] = 3'd1;
        tick();
        req_valid = '0;
        run(5);
        check_eq("sign_nres", r_data.size(), 1);
        if (r_data.size() > 0) check_eq("sign_data", r_data[0], 40'hC000000000);

        // Fairness: all requesters held valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = 40'({$urandom(), $urandom()});
            req_shift[i*3 +: 3]  = 3'($urandom());
        end
`ifdef FILTER_SHIFT_PRIO_EN
        exp_fair = '{0, 0, 0, 0, 0};
`else
        exp_fair = '{0, 1, 2, 3, 0};
`endif
        clear_log();
        req_valid = '1; out_ready = 1'b1;
        run(14);
        req_valid = '0;
        run(4);
        check_eq("fair_ngrant", g_idx.size() >= 5, 1);
        if (g_idx.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check_eq($sformatf("fair_idx%0d", k), g_idx[k], exp_fair[k]);
                if (k > 0) check_eq($sformatf("fair_gap%0d", k), g_cyc[k] - g_cyc[k-1], 3);
            end
        end

        // Backpressure: out_ready low for 10 cycles while requester 3 waits.
        req_valid = 4'b0100; req_data[2*DW +: DW] = 40'h123456789A; req_shift[8:6] = 3'd2;
        out_ready = 1'b0;
        tick();
        check_eq("bp_grant2", obs_rr, 4'b0100);
        req_valid = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (obs_ov) break;
        end
        check_eq("bp_ov_seen", obs_ov, 1);
        hold_data = obs_data; hold_id = obs_id;
        check_eq("bp_data", hold_data, 40'h048D159E26);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("bp_stable_data", obs_data, hold_data);
            check_eq("bp_stable_id", obs_id, 2);
            check_eq("bp_rr_zero", obs_rr, 4'b0000);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_hs_ov", obs_ov, 1);
        tick();
        check_eq("bp_next_grant", obs_rr, 4'b1000);
        req_valid = '0;
        run(5);

        // Mid-operation reset while holding a result.
        do_reset();
        req_valid = 4'b0010; out_ready = 1'b0;
        tick();
        req_valid = '0;
        run(2);
        check_eq("rst_in_hold", obs_ov, 1);
        rst_n = 1'b0; req_valid = '1;
        tick();
        check_eq("rst_ov", obs_ov, 0);
        check_eq("rst_busy", obs_busy, 0);
        check_eq("rst_rr", obs_rr, 4'b0000);
        rst_n = 1'b1;
        tick();
        check_eq("rst_first_grant", obs_rr, 4'b0001);
        req_valid = '0; out_ready = 1'b1;
        run(4);

        // Requesters 0 and 2 continuously valid.
        do_reset();
`ifdef FILTER_SHIFT_PRIO_EN
        exp_alt = '{0, 0, 0, 0};
`else
        exp_alt = '{0, 2, 0, 2};
`endif
        clear_log();
        req_valid = 4'b0101; out_ready = 1'b1;
        run(12);
        req_valid = '0;
        run(4);
        check_eq("alt_ngrant", g_idx.size(), 4);
        if (g_idx.size() >= 4) begin
            for (int k = 0; k < 4; k++) check_eq($sformatf("alt_idx%0d", k), g_idx[k], exp_alt[k]);
        end

        // Randomized traffic with occasional resets and backpressure.
        for (int c = 0; c < 800; c++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            req_valid = N'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_data[i*DW +: DW] = 40'({$urandom(), $urandom()});
                req_shift[i*3 +: 3]  = 3'($urandom());
            end
            tick();
        end
        rst_n = 1'b1; req_valid = '0; out_ready = 1'b1;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_shift_arbiter.md
FILTER_SHIFT_ARBITER -- requirements
Module: filter_shift_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one barrel shifter (range 2..8).
REQ-002 SHALL have parameter ID_W, default 2, meaning the width of the output channel tag (clog2 of NUM_REQ).
REQ-003 SHALL have the following ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_data  input  NUM_REQ*40  per-requester 40-bit operand; requester i occupies bits [40i+39:40i].
- req_shift  input  NUM_REQ*3  per-requester 3-bit shift select; requester i occupies bits [3i+2:3i].
- req_ready  output  NUM_REQ  one-hot grant/accept.
- out_valid  output  1  result valid.
- out_data  output  40  shifted result.
- out_id  output  ID_W  index of the requester that owns out_data.
- out_ready  input  1  downstream accept.
- busy  output  1  high in any state other than IDLE.

Function
REQ-004 SHALL instantiate exactly one filter_barrel_shifter: 40-bit input, 3-bit sel_shift, 40-bit output, arithmetic right shift by sel_shift.
REQ-005 SHALL implement the FSM states IDLE, SHIFT and HOLD.
REQ-006 In IDLE with any req_valid high, the block SHALL assert req_ready combinationally for exactly one winner in that cycle.
- It SHALL then capture the winner's data, shift and index into registers.
- It SHALL then go to SHIFT.
REQ-007 In IDLE with no req_valid, req_ready SHALL be all-zero and the state SHALL hold.
REQ-008 In SHIFT, the captured operand and shift SHALL drive the shifter, the shifter output SHALL be registered into out_data, out_id SHALL be loaded, and out_valid SHALL be set.
- The state SHALL then go to HOLD.
REQ-009 Latency SHALL be 2 cycles from the accept edge to out_valid high.
REQ-010 In HOLD, out_data and out_id SHALL stay stable until out_valid && out_ready.
- On that handshake, out_valid SHALL clear on the next edge and the state SHALL return to IDLE.
- Peak throughput SHALL be 1 result per 3 cycles.
REQ-011 req_ready SHALL be low in SHIFT and HOLD; requests arriving then SHALL wait and SHALL NOT be dropped.
REQ-012 Arbitration SHALL be round-robin.
- The search SHALL start at pointer rr_ptr.
- On each accept, rr_ptr SHALL be set to winner+1, modulo NUM_REQ.
REQ-013 When all requesters are valid simultaneously, the grant order SHALL be 0,1,2,...,NUM_REQ-1,0,...
REQ-014 A requester that drops req_valid before it is granted SHALL NOT be granted.
REQ-015 out_ready high while out_valid is low SHALL have no effect.
REQ-016 A req_valid deasserted or changed in the accept cycle after the edge SHALL NOT affect the captured values.

Reset
REQ-017 While rst_n is low, the block SHALL set the state to IDLE, rr_ptr to 0, out_valid to 0, out_data to 40'h0 and out_id to 0.
- req_ready SHALL be all-zero.
- busy SHALL be 0.
REQ-018 A reset asserted during SHIFT or HOLD SHALL discard the in-flight result with no output handshake.
REQ-019 After rst_n deasserts, the first grant SHALL be evaluated on the first rising edge.

Configuration
REQ-020 SHALL support the macro FILTER_SHIFT_PRIO_EN.
- When defined, requester 0 SHALL have strict priority: it wins whenever its req_valid is high in IDLE.
- When defined, the remaining requesters SHALL be round-robin among themselves, and rr_ptr SHALL NOT advance on requester-0 grants.
- When undefined, plain round-robin per REQ-012 SHALL apply.

Structure
REQ-021 Package filter_shift_pkg SHALL hold DATA_W=40, SHIFT_W=3, the FSM state enum (IDLE, SHIFT, HOLD) and a round-robin pick function.
REQ-022 filter_barrel_shifter SHALL be the only sub-module; arbitration and the FSM SHALL be in filter_shift_arbiter.

Verification
REQ-023 The bench SHALL cover single request:
- stimulus: req 1, data 40'h0000000FFF, shift 3, out_ready=1.
- required: out_valid 2 cycles after accept, out_data 40'h00000001FF, out_id 1.
REQ-024 The bench SHALL cover sign extension:
- stimulus: req 0, data 40'h8000000000, shift 1.
- required: out_data 40'hC000000000.
REQ-025 The bench SHALL cover fairness:
- stimulus: all 4 requesters held valid, out_ready=1.
- required: grant order 0,1,2,3,0, with one grant every 3 cycles.
REQ-026 The bench SHALL cover backpressure:
- stimulus: out_ready=0 for 10 cycles after out_valid.
- required: out_data and out_id stable, req_ready all-zero throughout, next grant one cycle after the handshake.
REQ-027 The bench SHALL cover mid-operation reset:
- stimulus: rst_n pulsed low in HOLD.
- required: out_valid=0 and busy=0 immediately, rr_ptr=0, requester 0 granted first afterwards.
REQ-028 The bench SHALL cover FILTER_SHIFT_PRIO_EN:
- stimulus: requesters 0 and 2 continuously valid.
- required: requester 0 granted every time and requester 2 starved; with the macro undefined, grants alternate 0,2,0,2.
